// File: rtl/qdiv_stream.sv
// qdiv_stream: sequential sign-magnitude fixed-point divider.
// It uses a restoring shift-subtract loop that resolves one quotient bit per cycle, MSB first.
// A valid/ready handshake sits on both the request side and the result side.
module qdiv_stream #(
  parameter int N     = 16,
  parameter int Q     = 8,
  parameter int TAG_W = 4,
  parameter int SAT   = 1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [N-1:0]     i_dividend,
  input  logic [N-1:0]     i_divisor,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [N-1:0]     o_quotient,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_overflow,
  output logic             o_dbz
);
  localparam int ITER = N + Q - 1;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic             sign;
    logic             dbz;
    logic [TAG_W-1:0] tag;
  } req_t;

  state_t          state_q, state_d;
  req_t            req_q;
  logic [CW-1:0]   cnt_q;
  logic [ITER-1:0] dq_q;     // Holds the unconsumed dividend bits and shifts quotient bits in from the bottom.
  logic [N-2:0]    rem_q;
  logic [N-2:0]    b_q;

  logic            accept, in_dbz, last;
  logic [N-1:0]    rem_sh;
  logic [N-2:0]    diff, rem_nx;
  logic            ge;
  logic [ITER-1:0] dq_nx;
  logic            res_ovf, res_sgn;
  logic [N-2:0]    res_mag;

  assign o_ready = (state_q == IDLE);
  assign accept  = i_valid & o_ready & ~i_flush;
  assign in_dbz  = (i_divisor[N-2:0] == '0);
  assign last    = (cnt_q == CW'(1));

  // Next-state logic. Flush overrides everything, including a same-cycle accept.
  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = BUSY;
        BUSY:    if (last) state_d = DONE;
        DONE:    if (i_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // One restoring step. The remainder stays below B, so the subtraction fits in N-1 bits.
  always_comb begin
    rem_sh  = {rem_q, dq_q[ITER-1]};
    ge      = (rem_sh >= {1'b0, b_q});
    diff    = rem_sh[N-2:0] - b_q;
    rem_nx  = ge ? diff : rem_sh[N-2:0];
    dq_nx   = {dq_q[ITER-2:0], ge};
    res_ovf = |dq_nx[ITER-1:N-1];
    res_mag = (res_ovf && SAT != 0) ? '1 : dq_nx[N-2:0];
    res_sgn = req_q.sign & (|res_mag);
  end

  // Datapath and result registers.
  // Divide-by-zero takes one pass through BUSY so that its result appears one edge after the accept.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      req_q      <= '0;
      cnt_q      <= '0;
      dq_q       <= '0;
      rem_q      <= '0;
      b_q        <= '0;
      o_valid    <= 1'b0;
      o_quotient <= '0;
      o_tag      <= '0;
      o_overflow <= 1'b0;
      o_dbz      <= 1'b0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          req_q.sign <= i_dividend[N-1] ^ i_divisor[N-1];
          req_q.dbz  <= in_dbz;
          req_q.tag  <= i_tag;
          dq_q       <= {i_dividend[N-2:0], {Q{1'b0}}};
          rem_q      <= '0;
          b_q        <= i_divisor[N-2:0];
          cnt_q      <= in_dbz ? CW'(1) : CW'(ITER);
        end
        BUSY: begin
          cnt_q <= cnt_q - CW'(1);
          dq_q  <= dq_nx;
          rem_q <= rem_nx;
          if (last) begin
            o_valid <= 1'b1;
            o_tag   <= req_q.tag;
            o_dbz   <= req_q.dbz;
            if (req_q.dbz) begin
              o_overflow <= 1'b1;
              o_quotient <= {req_q.sign, {(N-1){1'b1}}};
            end else begin
              o_overflow <= res_ovf;
              o_quotient <= {res_sgn, res_mag};
            end
          end
        end
        DONE: if (i_ready) o_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_qdiv_stream.sv
// Bench for qdiv_stream (N=16, Q=8). A SAT=1 instance and a SAT=0 instance share the same stimulus.
// Expected results come from a table and from an arithmetic reference model.
module tb_qdiv_stream;
  logic        clk = 1'b0;
  logic        rst_n, i_valid, i_flush, i_ready;
  logic [15:0] i_dividend, i_divisor;
  logic [3:0]  i_tag;
  logic        o_ready, o_valid, o_overflow, o_dbz;
  logic [15:0] o_quotient;
  logic [3:0]  o_tag;
  logic        o_ready0, o_valid0, o_overflow0, o_dbz0;
  logic [15:0] o_quotient0;
  logic [3:0]  o_tag0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  qdiv_stream #(.N(16), .Q(8), .TAG_W(4), .SAT(1)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_dividend(i_dividend), .i_divisor(i_divisor), .i_tag(i_tag), .i_flush(i_flush),
    .o_valid(o_valid), .i_ready(i_ready), .o_quotient(o_quotient), .o_tag(o_tag),
    .o_overflow(o_overflow), .o_dbz(o_dbz));

  qdiv_stream #(.N(16), .Q(8), .TAG_W(4), .SAT(0)) dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(i_valid), .o_ready(o_ready0),
    .i_dividend(i_dividend), .i_divisor(i_divisor), .i_tag(i_tag), .i_flush(i_flush),
    .o_valid(o_valid0), .i_ready(i_ready), .o_quotient(o_quotient0), .o_tag(o_tag0),
    .o_overflow(o_overflow0), .o_dbz(o_dbz0));

  typedef struct {
    logic [15:0] a, b;
    logic [3:0]  tag;
    logic [15:0] q1, q0;
    logic        ovf, dbz;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: F = floor(|a|*2^8 / |b|); overflow if F >= 2^15; no negative zero.
  // Returned as {dbz, ovf, quotient}.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input bit sat);
    longint f;
    logic   ovf, sgn;
    logic [14:0] mag;
    sgn = a[15] ^ b[15];
    if (b[14:0] == 15'd0) return {1'b1, 1'b1, sgn, 15'h7fff};
    f   = (longint'(a[14:0]) * 256) / longint'(b[14:0]);
    ovf = (f >= 32768);
    mag = (ovf && sat) ? 15'h7fff : 15'(f % 32768);
    if (mag == 15'd0) sgn = 1'b0;
    return {1'b0, ovf, sgn, mag};
  endfunction

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag,
                        input int hold, input logic [15:0] eq1, input logic [15:0] eq0,
                        input logic eovf, input logic edbz);
    int lat, w;
    logic stable;
    logic [15:0] snap;
    w = 0;
    while (!o_ready && w < 100) begin @(posedge clk); #1; w++; end
    chk("ready_before_req", {31'd0, o_ready}, 32'd1);
    i_dividend = a; i_divisor = b; i_tag = tag; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0; i_dividend = 16'($urandom); i_divisor = 16'($urandom); i_tag = ~tag;
    lat = 0;
    while (!o_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("latency", lat, edbz ? 32'd1 : 32'd23);
    chk("quotient_sat", {16'd0, o_quotient}, {16'd0, eq1});
    chk("quotient_wrap", {16'd0, o_quotient0}, {16'd0, eq0});
    chk("overflow", {30'd0, o_overflow0, o_overflow}, {30'd0, eovf, eovf});
    chk("dbz", {30'd0, o_dbz0, o_dbz}, {30'd0, edbz, edbz});
    chk("tag", {28'd0, o_tag}, {28'd0, tag});
    if (hold > 0) begin
      snap = o_quotient; stable = 1'b1;
      i_valid = 1'b1; i_dividend = 16'h0300; i_divisor = 16'h0100; i_tag = 4'h5;
      repeat (hold) begin
        @(posedge clk); #1;
        if (!o_valid || o_ready || o_quotient !== snap || o_tag !== tag) stable = 1'b0;
      end
      chk("hold_stable", {31'd0, stable}, 32'd1);
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0; i_valid = 1'b0;
    chk("consumed_valid", {31'd0, o_valid}, 32'd0);
    chk("ready_after", {31'd0, o_ready}, 32'd1);
  endtask

  task automatic check_cleared(input string name);
    chk(name, {o_valid, o_overflow, o_dbz, o_tag, o_quotient, o_ready},
        {3'b000, 4'h0, 16'h0000, 1'b1});
  endtask

  initial begin
    vec_t tbl[8];
    logic [17:0] e1, e0;
    logic [15:0] ra, rb;
    logic seen;

    tbl[0] = '{16'h0300, 16'h0200, 4'h1, 16'h0180, 16'h0180, 1'b0, 1'b0};
    tbl[1] = '{16'h8100, 16'h0400, 4'h2, 16'h8040, 16'h8040, 1'b0, 1'b0};
    tbl[2] = '{16'h0100, 16'h0300, 4'h3, 16'h0055, 16'h0055, 1'b0, 1'b0};
    tbl[3] = '{16'h8000, 16'h0100, 4'h4, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[4] = '{16'h7F00, 16'h0001, 4'h6, 16'h7FFF, 16'h0000, 1'b1, 1'b0};
    tbl[5] = '{16'h8100, 16'h8000, 4'h7, 16'h7FFF, 16'h7FFF, 1'b1, 1'b1};
    tbl[6] = '{16'hC000, 16'h0080, 4'h8, 16'hFFFF, 16'h0000, 1'b1, 1'b0};
    tbl[7] = '{16'h0001, 16'h7FFF, 4'h9, 16'h0000, 16'h0000, 1'b0, 1'b0};

    rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
    i_dividend = '0; i_divisor = '0; i_tag = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_cleared("reset_state");

    foreach (tbl[i])
      run_op(tbl[i].a, tbl[i].b, tbl[i].tag, 0, tbl[i].q1, tbl[i].q0, tbl[i].ovf, tbl[i].dbz);

    // Hold the result under backpressure, then the tag-5 request follows.
    run_op(16'h0300, 16'h0200, 4'hA, 10, 16'h0180, 16'h0180, 1'b0, 1'b0);
    run_op(16'h0100, 16'h0200, 4'h5, 0, 16'h0080, 16'h0080, 1'b0, 1'b0);

    // Flush at BUSY cycle 10; no result may appear afterwards.
    i_dividend = 16'h0300; i_divisor = 16'h0200; i_tag = 4'h3; i_valid = 1'b1;
    @(posedge clk); #1 i_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 i_flush = 1'b1;
    @(posedge clk); #1 i_flush = 1'b0;
    chk("flush_ready", {31'd0, o_ready}, 32'd1);
    seen = 1'b0;
    repeat (30) begin @(posedge clk); #1; if (o_valid) seen = 1'b1; end
    chk("flush_no_valid", {31'd0, seen}, 32'd0);

    // A flush in the same cycle as a request wins, so the request is not accepted.
    i_valid = 1'b1; i_flush = 1'b1;
    @(posedge clk); #1 i_valid = 1'b0; i_flush = 1'b0;
    chk("flush_beats_accept", {31'd0, o_ready}, 32'd1);

    // Reset mid-BUSY clears all outputs; a later request still works.
    i_dividend = 16'h0100; i_divisor = 16'h0300; i_tag = 4'hC; i_valid = 1'b1;
    @(posedge clk); #1 i_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    check_cleared("reset_mid_busy");
    run_op(16'h0300, 16'h0200, 4'hD, 0, 16'h0180, 16'h0180, 1'b0, 1'b0);

    // Random operands checked against the reference model.
    for (int k = 0; k < 40; k++) begin
      ra = 16'($urandom);
      case (k % 4)
        0: rb = 16'($urandom);
        1: rb = {1'($urandom), 15'($urandom_range(1, 255))};
        2: rb = {1'($urandom), 15'($urandom_range(0, 3))};
        default: rb = {1'($urandom), 15'($urandom_range(1, 32767))};
      endcase
      e1 = model(ra, rb, 1'b1);
      e0 = model(ra, rb, 1'b0);
      run_op(ra, rb, 4'($urandom), (k % 10 == 3) ? 3 : 0, e1[15:0], e0[15:0], e1[16], e1[17]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
